// File: rtl/rom_prefetch_ctrl_if.sv
// Bus between a fetch master and the ROM prefetch controller.
// Active-low strobes; rdy_ and wr_err are one-cycle slave responses.
interface rom_prefetch_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] rd_data;
    logic              rdy_;
    logic              wr_err;

    modport master (
        output cs_, as_, rw, addr,
        input  rd_data, rdy_, wr_err
    );

    modport slave (
        input  cs_, as_, rw, addr,
        output rd_data, rdy_, wr_err
    );
endinterface

// File: rtl/rom_prefetch_ctrl.sv
// Instruction ROM bus slave: hides the ROM's registered-read latency
// and keeps one sequentially prefetched word for linear fetch streams.
module rom_prefetch_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter bit PF_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    rom_prefetch_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        ACK,
        PF_ADDR,
        PF_DATA
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] last_addr;
    logic              last_rw;
    logic              pf_valid;
    logic [ADDR_W-1:0] pf_addr;
    logic [DATA_W-1:0] pf_data;
    logic [DATA_W-1:0] rd_data_q;
    logic              rdy_q;
    logic              wr_err_q;

    logic              req;
    logic              hit;
    logic [ADDR_W-1:0] next_addr;

    logic latch;
    logic go_miss;
    logic go_pf;
    logic ack_hit;
    logic ack_rom;
    logic ack_wr;
    logic ld_pf;

    assign req       = !bus.cs_ && !bus.as_;
    assign hit       = pf_valid && (pf_addr == bus.addr);
    assign next_addr = last_addr + ADDR_W'(1);

    assign bus.rd_data = rd_data_q;
    assign bus.rdy_    = rdy_q;
    assign bus.wr_err  = wr_err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        latch   = 1'b0;
        go_miss = 1'b0;
        go_pf   = 1'b0;
        ack_hit = 1'b0;
        ack_rom = 1'b0;
        ack_wr  = 1'b0;
        ld_pf   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    latch = 1'b1;
                    if (!bus.rw) begin
                        ack_wr  = 1'b1;
                        state_d = ACK;
                    end else if (hit) begin
                        ack_hit = 1'b1;
                        state_d = ACK;
                    end else begin
                        go_miss = 1'b1;
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: state_d = RD_DATA;
            RD_DATA: begin
                ack_rom = 1'b1;
                state_d = ACK;
            end
            ACK: begin
                // Writes never disturb the prefetch buffer.
                if (last_rw && PF_EN) begin
                    go_pf   = 1'b1;
                    state_d = PF_ADDR;
                end else begin
                    state_d = IDLE;
                end
            end
            PF_ADDR: state_d = PF_DATA;
            PF_DATA: begin
                ld_pf   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_addr <= '0;
            last_rw   <= 1'b0;
            rom_addr  <= '0;
            rd_data_q <= '0;
            rdy_q     <= 1'b1;
            wr_err_q  <= 1'b0;
            pf_valid  <= 1'b0;
            pf_addr   <= '0;
            pf_data   <= '0;
        end else begin
            if (latch) begin
                last_addr <= bus.addr;
                last_rw   <= bus.rw;
            end
            if (go_miss) begin
                rom_addr <= bus.addr;
            end
            if (go_pf) begin
                rom_addr <= next_addr;
            end
            if (ack_hit) begin
                rd_data_q <= pf_data;
            end
            if (ack_rom) begin
                rd_data_q <= rom_data;
            end
            rdy_q    <= !(ack_hit || ack_rom || ack_wr);
            wr_err_q <= ack_wr;
            if (ld_pf) begin
                pf_data  <= rom_data;
                pf_addr  <= next_addr;
                pf_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_rom_prefetch_ctrl.sv
// Bench for rom_prefetch_ctrl: two instances (prefetch on and off)
// against a transaction-level timing/data model of the controller.
module tb_rom_prefetch_ctrl;
    localparam int AW = 11;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n;

    rom_prefetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
    rom_prefetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

    logic [AW-1:0] rom_a0, rom_a1;
    logic [DW-1:0] rom_d0, rom_d1;

    rom_prefetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PF_EN(1'b1)) dut0 (
        .clk      (clk),
        .reset    (rst_n[0]),
        .bus      (bus0.slave),
        .rom_addr (rom_a0),
        .rom_data (rom_d0)
    );

    rom_prefetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .PF_EN(1'b0)) dut1 (
        .clk      (clk),
        .reset    (rst_n[1]),
        .bus      (bus1.slave),
        .rom_addr (rom_a1),
        .rom_data (rom_d1)
    );

    // ROM contents: mem[i] = A500_0000 | i, registered read.
    always @(posedge clk) begin
        rom_d0 <= 32'hA500_0000 | 32'(rom_a0);
        rom_d1 <= 32'hA500_0000 | 32'(rom_a1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          rdy_w [2];
    logic          wr_w  [2];
    logic [DW-1:0] rdd_w [2];
    logic [AW-1:0] rom_w [2];
    assign rdy_w[0] = bus0.rdy_;
    assign rdy_w[1] = bus1.rdy_;
    assign wr_w[0]  = bus0.wr_err;
    assign wr_w[1]  = bus1.wr_err;
    assign rdd_w[0] = bus0.rd_data;
    assign rdd_w[1] = bus1.rd_data;
    assign rom_w[0] = rom_a0;
    assign rom_w[1] = rom_a1;

    // Model state per instance.
    bit            pfen  [2] = '{1'b1, 1'b0};
    bit            pfv   [2];
    logic [AW-1:0] pfa   [2];
    logic [AW-1:0] rom_m [2];
    logic [DW-1:0] rd_m  [2];
    int            free  [2];

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input int k, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL dut%0d %s cyc=%0d got=%h want=%h",
                     k, nm, cyc, act, exp);
        end
    endtask

    task automatic drive(input int k, input bit cs, input bit as,
                         input bit rwv, input logic [AW-1:0] a);
        if (k == 0) begin
            bus0.cs_ = cs; bus0.as_ = as; bus0.rw = rwv; bus0.addr = a;
        end else begin
            bus1.cs_ = cs; bus1.as_ = as; bus1.rw = rwv; bus1.addr = a;
        end
    endtask

    task automatic chk_idle(input int k);
        chk(k, "idle rdy_", 32'(rdy_w[k]), 32'd1);
        chk(k, "idle wr_err", 32'(wr_w[k]), 32'd0);
        chk(k, "idle rom_addr", 32'(rom_w[k]), 32'(rom_m[k]));
        chk(k, "idle rd_data", rdd_w[k], rd_m[k]);
    endtask

    // n cycles without a request; bogus=1 drives half strobes.
    task automatic gap(input int k, input int n, input bit bogus);
        bit c;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (bogus) begin
                c = 1'($urandom_range(0, 1));
                drive(k, c, !c, 1'($urandom_range(0, 1)),
                      AW'($urandom_range(0, 2047)));
            end else begin
                drive(k, 1'b1, 1'b1, 1'b1, '0);
            end
            @(negedge clk);
            chk_idle(k);
        end
    endtask

    // One master transaction; lat = cycles from presenting the
    // request to the rdy_ strobe (-1 if never seen).
    task automatic xact(input int k, input bit rwv,
                        input logic [AW-1:0] a, output int lat,
                        output logic [31:0] dat, output bit werr);
        int t0, s, r;
        bit hit, miss;
        logic [31:0] exp_d;
        @(posedge clk); #1;
        drive(k, 1'b0, 1'b0, rwv, a);
        t0    = cyc;
        s     = (t0 + 1 > free[k]) ? t0 + 1 : free[k];
        hit   = rwv && pfv[k] && (pfa[k] == a);
        miss  = rwv && !hit;
        r     = miss ? s + 2 : s;
        exp_d = rwv ? (32'hA500_0000 | 32'(a)) : rd_m[k];
        lat   = -1;
        dat   = '0;
        werr  = 1'b0;
        do begin
            @(negedge clk);
            chk(k, "rdy_", 32'(rdy_w[k]), (cyc == r) ? 32'd0 : 32'd1);
            chk(k, "wr_err", 32'(wr_w[k]), 32'(cyc == r && !rwv));
            chk(k, "rom_addr", 32'(rom_w[k]),
                (miss && cyc >= s) ? 32'(a) : 32'(rom_m[k]));
            if (cyc == r) chk(k, "rd_data", rdd_w[k], exp_d);
            if (!rdy_w[k] && lat < 0) begin
                lat  = cyc - t0;
                dat  = rdd_w[k];
                werr = wr_w[k];
            end
        end while (cyc < r);
        @(posedge clk); #1;
        drive(k, 1'b1, 1'b1, 1'b1, '0);
        if (rwv) rd_m[k] = exp_d;
        if (miss) rom_m[k] = a;
        if (rwv && pfen[k]) begin
            pfv[k]   = 1'b1;
            pfa[k]   = AW'(a + 1);
            rom_m[k] = AW'(a + 1);
            free[k]  = r + 4;
        end else begin
            free[k] = r + 2;
        end
        @(negedge clk);
        chk_idle(k);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int            lat;
        logic [31:0]   dat;
        bit            werr;
        int            r;
        bit            rwv;
        logic [AW-1:0] a, last;

        rst_n = 2'b00;
        drive(0, 1'b1, 1'b1, 1'b1, '0);
        drive(1, 1'b1, 1'b1, 1'b1, '0);
        for (int k = 0; k < 2; k++) begin
            pfv[k] = 1'b0; pfa[k] = '0; rom_m[k] = '0;
            rd_m[k] = '0; free[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk(k, "reset rdy_", 32'(rdy_w[k]), 32'd1);
            chk(k, "reset rd_data", rdd_w[k], 32'd0);
            chk(k, "reset wr_err", 32'(wr_w[k]), 32'd0);
            chk(k, "reset rom_addr", 32'(rom_w[k]), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 2'b11;
        free[0] = cyc + 1;
        free[1] = cyc + 1;

        // Directed sequence, prefetch enabled.
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h010, lat, dat, werr);
        chk(0, "cold lat", 32'(lat), 32'd3);
        chk(0, "cold data", dat, 32'hA500_0010);
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h011, lat, dat, werr);
        chk(0, "seq lat", 32'(lat), 32'd1);
        chk(0, "seq data", dat, 32'hA500_0011);
        gap(0, 3, 1'b0);
        chk(0, "pf rom_addr", 32'(rom_w[0]), 32'h012);
        xact(0, 1'b1, 11'h100, lat, dat, werr);
        chk(0, "jump lat", 32'(lat), 32'd3);
        chk(0, "jump data", dat, 32'hA500_0100);
        gap(0, 3, 1'b0);
        chk(0, "jump pf rom_addr", 32'(rom_w[0]), 32'h101);
        xact(0, 1'b1, 11'h101, lat, dat, werr);
        chk(0, "jump pf hit lat", 32'(lat), 32'd1);
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h7FF, lat, dat, werr);
        chk(0, "top lat", 32'(lat), 32'd3);
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h000, lat, dat, werr);
        chk(0, "wrap lat", 32'(lat), 32'd1);
        chk(0, "wrap data", dat, 32'hA500_0000);
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h011, lat, dat, werr);
        gap(0, 3, 1'b0);
        xact(0, 1'b0, 11'h020, lat, dat, werr);
        chk(0, "write lat", 32'(lat), 32'd1);
        chk(0, "write wr_err", 32'(werr), 32'd1);
        chk(0, "write rd_data held", dat, 32'hA500_0011);
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h012, lat, dat, werr);
        chk(0, "post-write hit lat", 32'(lat), 32'd1);
        chk(0, "post-write hit data", dat, 32'hA500_0012);
        // Back-to-back: request arrives while 0x201 is being prefetched.
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h200, lat, dat, werr);
        xact(0, 1'b1, 11'h201, lat, dat, werr);
        chk(0, "held req lat", 32'(lat), 32'd2);
        chk(0, "held req data", dat, 32'hA500_0201);

        // Reset in the middle of a ROM read.
        gap(0, 3, 1'b0);
        xact(0, 1'b1, 11'h030, lat, dat, werr);
        gap(0, 3, 1'b0);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1'b1, 11'h050);
        @(posedge clk);
        @(posedge clk); #1;
        chk(0, "abort rom_addr", 32'(rom_w[0]), 32'h050);
        rst_n[0] = 1'b0;
        drive(0, 1'b1, 1'b1, 1'b1, '0);
        #1;
        chk(0, "abort rdy_", 32'(rdy_w[0]), 32'd1);
        chk(0, "abort rd_data", rdd_w[0], 32'd0);
        chk(0, "abort wr_err", 32'(wr_w[0]), 32'd0);
        chk(0, "abort rom_addr rst", 32'(rom_w[0]), 32'd0);
        @(posedge clk); #1;
        rst_n[0] = 1'b1;
        pfv[0] = 1'b0; rd_m[0] = '0; rom_m[0] = '0;
        free[0] = cyc + 1;
        gap(0, 4, 1'b0);
        xact(0, 1'b1, 11'h031, lat, dat, werr);
        chk(0, "post-reset lat", 32'(lat), 32'd3);
        chk(0, "post-reset data", dat, 32'hA500_0031);

        // Prefetch disabled: sequential stream still misses.
        for (int i = 0; i < 4; i++) begin
            gap(1, 2, 1'b0);
            xact(1, 1'b1, AW'(i), lat, dat, werr);
            chk(1, "nopf lat", 32'(lat), 32'd3);
            chk(1, "nopf data", dat, 32'hA500_0000 | 32'(i));
            chk(1, "nopf rom_addr", 32'(rom_w[1]), 32'(i));
        end

        // Randomized traffic on both instances.
        for (int k = 0; k < 2; k++) begin
            last = rom_m[k];
            for (int n = 0; n < 60; n++) begin
                r = $urandom_range(0, 9);
                if (r < 5)      a = AW'(last + 1);
                else if (r < 6) a = pfa[k];
                else if (r < 8) a = AW'(11'h7FE + AW'($urandom_range(0, 1)));
                else            a = AW'($urandom_range(0, 2047));
                rwv = ($urandom_range(0, 9) != 0);
                xact(k, rwv, a, lat, dat, werr);
                if (rwv) last = a;
                gap(k, $urandom_range(0, 2), 1'b1);
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
